// File: rtl/bus_rr_router_n_if.sv
// ---------------------------------------------------------------------------
// bus_rr_router_n_if
//   Bundles the device-side signals of the shared-bus router: FIFO heads and
//   pops on the send side, ready/push on the receive side, plus the router's
//   status and statistics outputs.
//
//   pndng    [drvrs]          device i has a packet at its FIFO head
//   D_pop    [drvrs*pckg_sz]  show-ahead head data, slice i = [i*pckg_sz +: pckg_sz]
//   pop      [drvrs]          one-hot pop strobe back to the sending FIFO
//   rdy      [drvrs]          device i can accept a push this cycle
//   push     [drvrs]          write strobe into device i
//   D_push   [drvrs*pckg_sz]  per-device write data, same slicing as D_pop
//   busy                      router is in a transaction
//   xfer_cnt [16]             delivered packets, saturating
//   drop_cnt [16]             dropped packets, saturating
//
//   master: the router. slave: the attached devices (or a testbench).
// ---------------------------------------------------------------------------
interface bus_rr_router_n_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         rdy;
  logic [drvrs-1:0]         push;
  logic [drvrs*pckg_sz-1:0] D_push;
  logic                     busy;
  logic [15:0]              xfer_cnt;
  logic [15:0]              drop_cnt;

  modport master (
    input  pndng, D_pop, rdy,
    output pop, push, D_push, busy, xfer_cnt, drop_cnt
  );

  modport slave (
    output pndng, D_pop, rdy,
    input  pop, push, D_push, busy, xfer_cnt, drop_cnt
  );
endinterface

// File: rtl/bus_rr_router_n.sv
// ---------------------------------------------------------------------------
// bus_rr_router_n
//   Shared-bus router for `drvrs` device FIFOs. Pending senders are granted
//   round-robin; the granted head packet is popped, decoded by its
//   destination-ID field (top id_w bits) and pushed to one device, or to every
//   device except the sender when the ID equals `bcast`. Delivery waits until
//   all targets are ready at once; after `tmo` waiting cycles (0 = never) the
//   packet is dropped. Invalid / self-addressed IDs are dropped too.
//
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    bus_rr_router_n_if.master (pndng, D_pop, rdy in; pop, push,
//          D_push, busy, xfer_cnt, drop_cnt out)
// ---------------------------------------------------------------------------
module bus_rr_router_n #(
  parameter int                drvrs   = 4,
  parameter int                pckg_sz = 16,
  parameter int                id_w    = 8,
  parameter logic [id_w-1:0]   bcast   = 8'hFF,
  parameter int                tmo     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_rr_router_n_if.master     bus
);

  localparam int SW = $clog2(drvrs);
  localparam int CW = (tmo > 1) ? $clog2(tmo + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_ROUTE,
    S_WAIT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [SW-1:0]             r_src;
  logic [SW-1:0]             r_last;
  logic [pckg_sz-1:0]        r_pkt;
  logic [drvrs-1:0]          r_targets;
  logic [CW-1:0]             r_wait;
  logic [15:0]               r_xfer;
  logic [15:0]               r_drop;
  logic [drvrs*pckg_sz-1:0]  r_d_push;

  logic [SW-1:0]             w_grant;
  logic                      w_grant_vld;
  logic [id_w-1:0]           w_id;
  logic [drvrs-1:0]          w_targets;
  logic                      w_id_ok;
  logic                      w_all_rdy;
  logic [CW-1:0]             w_wait_nxt;
  logic                      w_tmo_hit;
  logic [drvrs-1:0]          w_push;

  // Round-robin search: first pending device after the last grant, wrapping.
  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_grant     = r_last;
    w_grant_vld = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      if (!w_grant_vld && bus.pndng[(int'(r_last) + k) % drvrs]) begin
        w_grant_vld = 1'b1;
        w_grant     = SW'((int'(r_last) + k) % drvrs);
      end
    end
  end

  // Destination decode of the captured packet.
  assign w_id = r_pkt[pckg_sz-1 -: id_w];

  always_comb begin
    w_targets = '0;
    w_id_ok   = 1'b0;
    if (w_id == bcast) begin
      w_id_ok = 1'b1;
      for (int i = 0; i < drvrs; i++) begin
        if (i != int'(r_src)) w_targets[i] = 1'b1;
      end
    end else if ((int'(w_id) < drvrs) && (int'(w_id) != int'(r_src))) begin
      w_id_ok = 1'b1;
      for (int i = 0; i < drvrs; i++) begin
        if (int'(w_id) == i) w_targets[i] = 1'b1;
      end
    end
  end

  // Delivery is all-or-nothing: every target must be ready in the same cycle.
  assign w_all_rdy  = ((bus.rdy & r_targets) == r_targets);
  assign w_wait_nxt = r_wait + CW'(1);
  assign w_tmo_hit  = (tmo != 0) && (int'(w_wait_nxt) == tmo);

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = '0;
    bus.pop     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_vld) w_state_nxt = S_POP;
      end
      S_POP: begin
        for (int i = 0; i < drvrs; i++) begin
          if (int'(r_src) == i) bus.pop[i] = 1'b1;
        end
        w_state_nxt = S_ROUTE;
      end
      S_ROUTE: begin
        w_state_nxt = w_id_ok ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (w_all_rdy) begin
          w_push      = r_targets;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Targets see the packet in the push cycle; every other slice keeps the
  // last value that was delivered to it.
  always_comb begin
    bus.D_push = r_d_push;
    for (int i = 0; i < drvrs; i++) begin
      if (w_push[i]) bus.D_push[i*pckg_sz +: pckg_sz] = r_pkt;
    end
  end

  assign bus.push     = w_push;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.xfer_cnt = r_xfer;
  assign bus.drop_cnt = r_drop;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_last    <= SW'(drvrs - 1);
      r_pkt     <= '0;
      r_targets <= '0;
      r_wait    <= '0;
      r_xfer    <= '0;
      r_drop    <= '0;
      r_d_push  <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_src  <= w_grant;
            r_last <= w_grant;
          end
        end
        S_POP: begin
          r_pkt <= bus.D_pop[int'(r_src)*pckg_sz +: pckg_sz];
        end
        S_ROUTE: begin
          if (w_id_ok) begin
            r_targets <= w_targets;
            r_wait    <= '0;
          end else if (r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
          end
        end
        S_WAIT: begin
          if (w_all_rdy) begin
            if (r_xfer != 16'hFFFF) r_xfer <= r_xfer + 16'd1;
            for (int i = 0; i < drvrs; i++) begin
              if (r_targets[i]) r_d_push[i*pckg_sz +: pckg_sz] <= r_pkt;
            end
          end else if (tmo != 0) begin
            r_wait <= w_wait_nxt;
            if (w_tmo_hit && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
